sync_fifo_ctrl: RTL and testbench
=================================

# sync_fifo_ctrl

Parametrised synchronous FIFO, the next generation of the UART-path byte FIFO. It adds a fill-level counter, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow flags. It also adds a synchronous flush and a selectable read mode: first-word fall-through, or registered read with a valid strobe. It sits between the UART RX/TX engines and the bus/command logic, and replaces the fixed-depth FIFO wherever flow-control watermarks are needed.

## Interface
- DATA_WIDTH, 8: word width
- ADDR_WIDTH, 4: depth = 2**ADDR_WIDTH
- AFULL_LVL, 2**ADDR_WIDTH-2: almost_full asserts when count >= AFULL_LVL
- AEMPTY_LVL, 2: almost_empty asserts when count <= AEMPTY_LVL
- FWFT, 1: 1 = fall-through read; 0 = registered read, 1-cycle latency
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- wdata  in  DATA_WIDTH  write data
- rd_en  in  1  read request (pop)
- flush  in  1  synchronous empty-the-FIFO
- clr_err  in  1  synchronous clear of sticky error flags
- rdata  out  DATA_WIDTH  read data
- rvalid  out  1  rdata valid
- full, empty  out  1  status flags
- almost_full, almost_empty  out  1  watermark flags
- count  out  ADDR_WIDTH+1  stored words, 0..2**ADDR_WIDTH
- overflow, underflow  out  1  sticky error flags

## Operation
- Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty: pointers equal.
  - full: MSBs differ and low bits equal.
  - count = w_ptr - r_ptr, modulo 2**(ADDR_WIDTH+1).
- Write is accepted when wr_en && !full. Read is accepted when rd_en && !empty. Both use the current-cycle flags.
- Simultaneous wr_en/rd_en:
  - When neither full nor empty: both accepted, count unchanged.
  - When full: read only. The write is dropped and overflow is set.
  - When empty: write only. underflow is set.
- wr_en while full sets overflow. rd_en while empty sets underflow. Pointers do not move on a rejected access.
- Sticky flags: clr_err clears both. If an error occurs in the same cycle as clr_err, set wins.
- flush has priority over wr_en/rd_en in the same cycle.
  - Both pointers go to 0. In FWFT=0 mode, rvalid goes to 0.
  - Sticky flags and memory contents are unaffected.
- FWFT=1:
  - rdata = mem[r_ptr[ADDR_WIDTH-1:0]], combinational.
  - rvalid = !empty.
  - rd_en pops the word currently shown.
- FWFT=0:
  - An accepted read loads rdata at the clock edge; rvalid is high for exactly the following cycle.
  - Back-to-back reads give a continuous rvalid.
  - rdata holds its last value otherwise.
- Memory is not reset. Only the pointers, rdata register and flags are reset.

## Timing
- Reset values: rdata 0, rvalid 0, full 0, empty 1, almost_full 0, almost_empty 1, count 0, overflow 0, underflow 0. rst mid-operation discards all contents immediately (asynchronous).
- All status outputs are decoded from registered pointers and flags. There is no combinational path from wr_en or rd_en to any status output.
- Write to read, FWFT=1: write accepted at edge N → empty falls and rdata is valid after edge N, so the word can be popped in cycle N+1.
- Write to read, FWFT=0: the read is accepted in cycle N+1 at the earliest, and data appears after edge N+1.
- Pointer wrap-around at 2**ADDR_WIDTH is seamless. The wrap bit toggles, and no bubble is inserted.
- Throughput: one write and one read per cycle sustained.

## Structure
- Shared package fifo_pkg holds:
  - the pointer-width constant expression (ADDR_WIDTH+1);
  - the read-mode constants FWFT_MODE=1 and REG_MODE=0.
- Sub-module fifo_mem: simple dual-port array with synchronous write and asynchronous read, parametrised by DATA_WIDTH and ADDR_WIDTH.
- Control logic, pointers, flags and the read-data register live in sync_fifo_ctrl.

## Test plan
- Reset, then 16 writes 0x00..0x0F (ADDR_WIDTH=4) → count 16, full=1, almost_full asserted at count 14. A 17th write sets overflow, and the contents are unchanged.
- Drain all 16 with FWFT=1 → rdata sequence 0x00..0x0F. almost_empty asserts at count 2, and empty=1 after the last pop. One extra rd_en sets underflow.
- FWFT=0: write 0xA5 then 0x5A, then pop twice back-to-back → rvalid high two consecutive cycles with 0xA5 then 0x5A. rdata holds 0x5A afterwards.
- Simultaneous wr_en/rd_en:
  - at count 5 for 20 cycles → count stays 5, data order preserved across the pointer wrap;
  - while full → read only, overflow=1;
  - while empty → write only, underflow=1.
- flush with count 9 and wr_en high in the same cycle → next cycle count 0, empty=1, write dropped. The sticky flags keep their values until clr_err.
- Assert rst mid-burst at count 7 → all outputs return to reset values immediately. A write of 0x3C after release reads back 0x3C.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO family: pointer width and read-mode encodings.
package fifo_pkg;

    localparam int FWFT_MODE = 1;
    localparam int REG_MODE  = 0;

    // Pointers carry one extra wrap bit above the address bits.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO with fill count, watermarks, sticky error flags, flush and
// selectable fall-through or registered read.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_LVL  = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_LVL = 2,
    parameter int FWFT       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    logic [PTR_W-1:0]      w_ptr_r;
    logic [PTR_W-1:0]      r_ptr_r;
    logic [PTR_W-1:0]      count_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic                  wr_err_s;
    logic                  rd_err_s;
    logic                  overflow_r;
    logic                  underflow_r;
    logic [DATA_WIDTH-1:0] mem_rdata_s;

    // Status decode from registered pointers only.
    always_comb begin
        count_s = w_ptr_r - r_ptr_r;
        empty_s = (w_ptr_r == r_ptr_r);
        full_s  = (w_ptr_r[PTR_W-1] != r_ptr_r[PTR_W-1]) &&
                  (w_ptr_r[PTR_W-2:0] == r_ptr_r[PTR_W-2:0]);
    end

    // Access acceptance and error detection; flush suppresses both.
    always_comb begin
        wr_accept_s = 1'b0;
        rd_accept_s = 1'b0;
        wr_err_s    = 1'b0;
        rd_err_s    = 1'b0;
        if (!flush) begin
            wr_accept_s = wr_en && !full_s;
            rd_accept_s = rd_en && !empty_s;
            wr_err_s    = wr_en && full_s;
            rd_err_s    = rd_en && empty_s;
        end else begin
            wr_accept_s = 1'b0;
            rd_accept_s = 1'b0;
            wr_err_s    = 1'b0;
            rd_err_s    = 1'b0;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_r <= {PTR_W{1'b0}};
            r_ptr_r <= {PTR_W{1'b0}};
        end else if (flush) begin
            w_ptr_r <= {PTR_W{1'b0}};
            r_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (wr_accept_s) begin
                w_ptr_r <= w_ptr_r + PTR_W'(1);
            end
            if (rd_accept_s) begin
                r_ptr_r <= r_ptr_r + PTR_W'(1);
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_err_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (rd_err_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept_s),
        .waddr (w_ptr_r[PTR_W-2:0]),
        .wdata (wdata),
        .raddr (r_ptr_r[PTR_W-2:0]),
        .rdata (mem_rdata_s)
    );

    generate
        if (FWFT == FWFT_MODE) begin : g_fwft
            assign rdata  = mem_rdata_s;
            assign rvalid = !empty_s;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_r;
            logic                  rvalid_r;

            // Registered read: data captured on an accepted pop, valid for one cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_r  <= {DATA_WIDTH{1'b0}};
                    rvalid_r <= 1'b0;
                end else if (flush) begin
                    rvalid_r <= 1'b0;
                end else begin
                    rvalid_r <= rd_accept_s;
                    if (rd_accept_s) begin
                        rdata_r <= mem_rdata_s;
                    end
                end
            end

            assign rdata  = rdata_r;
            assign rvalid = rvalid_r;
        end
    endgenerate

    assign count        = count_s;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_s >= PTR_W'(AFULL_LVL));
    assign almost_empty = (count_s <= PTR_W'(AEMPTY_LVL));
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: one fall-through and one registered-read
// instance driven by the same stimulus.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rd_en = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] f_rdata, r_rdata;
    logic       f_rvalid, r_rvalid, f_full, r_full, f_empty, r_empty;
    logic       f_af, r_af, f_ae, r_ae, f_ov, r_ov, f_un, r_un;
    logic [4:0] f_count, r_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(1)) u_dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .rdata(f_rdata), .rvalid(f_rvalid),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ov), .underflow(f_un)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(0)) u_dut_r (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .rdata(r_rdata), .rvalid(r_rvalid),
        .full(r_full), .empty(r_empty), .almost_full(r_af), .almost_empty(r_ae),
        .count(r_count), .overflow(r_ov), .underflow(r_un)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        wr_en = 1'b1;
        wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        tests++; if ({f_count, f_full, f_empty, f_af, f_ae, f_ov, f_un, f_rvalid} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset_fwft got=%b want=%b", {f_count, f_full, f_empty, f_af, f_ae, f_ov, f_un, f_rvalid}, 12'b000000101000);
        end
        tests++; if ({r_count, r_empty, r_rvalid, r_rdata} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
            fails++; $display("FAIL reset_reg got=%h want=%h", {r_count, r_empty, r_rvalid, r_rdata}, {5'd0, 1'b1, 1'b0, 8'h00});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            write_word(8'(i));
            tests++; if (f_count !== 5'(i + 1)) begin
                fails++; $display("FAIL fill_count got=%0d want=%0d", f_count, i + 1);
            end
            tests++; if (f_af !== ((i + 1) >= 14)) begin
                fails++; $display("FAIL fill_afull count=%0d got=%b want=%b", i + 1, f_af, ((i + 1) >= 14));
            end
        end
        tests++; if (f_full !== 1'b1 || f_ov !== 1'b0) begin
            fails++; $display("FAIL fill_full got full=%b ov=%b want full=1 ov=0", f_full, f_ov);
        end
        write_word(8'hFF);
        tests++; if (f_ov !== 1'b1 || f_count !== 5'd16) begin
            fails++; $display("FAIL overflow got ov=%b count=%0d want ov=1 count=16", f_ov, f_count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            tests++; if (f_rdata !== 8'(i) || f_rvalid !== 1'b1) begin
                fails++; $display("FAIL drain_data got=%h/%b want=%h/1", f_rdata, f_rvalid, 8'(i));
            end
            tests++; if (f_ae !== ((16 - i) <= 2)) begin
                fails++; $display("FAIL drain_aempty count=%0d got=%b want=%b", 16 - i, f_ae, ((16 - i) <= 2));
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        tests++; if (f_empty !== 1'b1 || f_un !== 1'b0 || f_rvalid !== 1'b0) begin
            fails++; $display("FAIL drain_empty got empty=%b un=%b rvalid=%b want 1/0/0", f_empty, f_un, f_rvalid);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tests++; if (f_un !== 1'b1 || f_count !== 5'd0) begin
            fails++; $display("FAIL underflow got un=%b count=%0d want un=1 count=0", f_un, f_count);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests++; if (f_ov !== 1'b0 || f_un !== 1'b0) begin
            fails++; $display("FAIL clr_err got ov=%b un=%b want 0/0", f_ov, f_un);
        end
    endtask

    task automatic test_reg_read();
        write_word(8'hA5);
        write_word(8'h5A);
        tests++; if (r_rvalid !== 1'b0 || r_count !== 5'd2) begin
            fails++; $display("FAIL reg_idle got rvalid=%b count=%0d want 0/2", r_rvalid, r_count);
        end
        rd_en = 1'b1;
        tick();
        tests++; if (r_rvalid !== 1'b1 || r_rdata !== 8'hA5) begin
            fails++; $display("FAIL reg_first got=%b/%h want=1/a5", r_rvalid, r_rdata);
        end
        tick();
        rd_en = 1'b0;
        tests++; if (r_rvalid !== 1'b1 || r_rdata !== 8'h5A) begin
            fails++; $display("FAIL reg_second got=%b/%h want=1/5a", r_rvalid, r_rdata);
        end
        tick();
        tests++; if (r_rvalid !== 1'b0 || r_rdata !== 8'h5A || r_empty !== 1'b1) begin
            fails++; $display("FAIL reg_hold got=%b/%h empty=%b want=0/5a empty=1", r_rvalid, r_rdata, r_empty);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) begin
            write_word(8'h10 + 8'(i));
        end
        wr_en = 1'b1;
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wdata = 8'h15 + 8'(k);
            tests++; if (f_rdata !== 8'h10 + 8'(k)) begin
                fails++; $display("FAIL simul_data k=%0d got=%h want=%h", k, f_rdata, 8'h10 + 8'(k));
            end
            tick();
            tests++; if (f_count !== 5'd5 || r_rdata !== 8'h10 + 8'(k)) begin
                fails++; $display("FAIL simul_count k=%0d got=%0d/%h want=5/%h", k, f_count, r_rdata, 8'h10 + 8'(k));
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_full_simul_and_flush();
        for (int i = 0; i < 11; i++) begin
            write_word(8'h40 + 8'(i));
        end
        tests++; if (f_full !== 1'b1 || f_count !== 5'd16) begin
            fails++; $display("FAIL refill got full=%b count=%0d want 1/16", f_full, f_count);
        end
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'hEE;
        tests++; if (f_rdata !== 8'h24) begin
            fails++; $display("FAIL full_simul_head got=%h want=24", f_rdata);
        end
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        tests++; if (f_count !== 5'd15 || f_ov !== 1'b1 || f_un !== 1'b0 || f_rdata !== 8'h25) begin
            fails++; $display("FAIL full_simul got count=%0d ov=%b un=%b rdata=%h want 15/1/0/25", f_count, f_ov, f_un, f_rdata);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++; if (f_count !== 5'd0 || f_empty !== 1'b1 || f_ov !== 1'b1) begin
            fails++; $display("FAIL flush_full got count=%0d empty=%b ov=%b want 0/1/1", f_count, f_empty, f_ov);
        end
        for (int i = 0; i < 9; i++) begin
            write_word(8'h60 + 8'(i));
        end
        tests++; if (f_count !== 5'd9) begin
            fails++; $display("FAIL flush_prefill got=%0d want=9", f_count);
        end
        flush = 1'b1;
        wr_en = 1'b1;
        wdata = 8'h99;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        tests++; if (f_count !== 5'd0 || f_empty !== 1'b1 || f_ov !== 1'b1 || r_rvalid !== 1'b0) begin
            fails++; $display("FAIL flush_wr got count=%0d empty=%b ov=%b rvalid=%b want 0/1/1/0", f_count, f_empty, f_ov, r_rvalid);
        end
    endtask

    task automatic test_empty_simul();
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'h77;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        tests++; if (f_count !== 5'd1 || f_un !== 1'b1 || f_rdata !== 8'h77 || f_ov !== 1'b1) begin
            fails++; $display("FAIL empty_simul got count=%0d un=%b rdata=%h ov=%b want 1/1/77/1", f_count, f_un, f_rdata, f_ov);
        end
        rd_en = 1'b1;
        tick();
        clr_err = 1'b1;
        tick();
        rd_en = 1'b0;
        clr_err = 1'b0;
        tests++; if (f_un !== 1'b1 || f_ov !== 1'b0) begin
            fails++; $display("FAIL set_wins got un=%b ov=%b want 1/0", f_un, f_ov);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests++; if (f_un !== 1'b0 || f_ov !== 1'b0) begin
            fails++; $display("FAIL clr_err2 got un=%b ov=%b want 0/0", f_un, f_ov);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            write_word(8'h80 + 8'(i));
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        write_word(8'h87);
        tests++; if (f_count !== 5'd7 || r_rdata !== 8'h80) begin
            fails++; $display("FAIL mid_prefill got count=%0d rdata=%h want 7/80", f_count, r_rdata);
        end
        wr_en = 1'b1;
        wdata = 8'h88;
        tick();
        #1;
        rst = 1'b1;
        #1;
        tests++; if ({f_count, f_full, f_empty, f_af, f_ae, f_ov, f_un} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            fails++; $display("FAIL mid_reset_f got=%b want=%b", {f_count, f_full, f_empty, f_af, f_ae, f_ov, f_un}, 11'b00000010100);
        end
        tests++; if ({r_count, r_rvalid, r_rdata} !== {5'd0, 1'b0, 8'h00}) begin
            fails++; $display("FAIL mid_reset_r got=%h want=%h", {r_count, r_rvalid, r_rdata}, 14'h0);
        end
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        write_word(8'h3C);
        tests++; if (f_rdata !== 8'h3C || f_count !== 5'd1) begin
            fails++; $display("FAIL post_reset_f got=%h count=%0d want 3c/1", f_rdata, f_count);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tests++; if (r_rvalid !== 1'b1 || r_rdata !== 8'h3C) begin
            fails++; $display("FAIL post_reset_r got=%b/%h want=1/3c", r_rvalid, r_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_reg_read();
        test_simultaneous();
        test_full_simul_and_flush();
        test_empty_simul();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
